// File: rtl/servant_muxn_if.sv
// Wishbone bundle between the SERV data bus, servant_muxn and its NUM_SLAVES peripherals,
// including the bus-error logging signals.
interface servant_muxn_if #(
    parameter int NUM_SLAVES = 4
);
    logic [31:0]            i_wb_cpu_adr;
    logic [31:0]            i_wb_cpu_dat;
    logic [3:0]             i_wb_cpu_sel;
    logic                   i_wb_cpu_we;
    logic                   i_wb_cpu_cyc;
    logic [31:0]            o_wb_cpu_rdt;
    logic                   o_wb_cpu_ack;
    logic [31:0]            o_wb_s_adr;
    logic [31:0]            o_wb_s_dat;
    logic [3:0]             o_wb_s_sel;
    logic                   o_wb_s_we;
    logic [NUM_SLAVES-1:0]  o_wb_s_cyc;
    logic [32*NUM_SLAVES-1:0] i_wb_s_rdt;
    logic [NUM_SLAVES-1:0]  i_wb_s_ack;
    logic                   o_err;
    logic [31:0]            o_err_adr;
    logic                   i_err_clr;

    modport slave (
        input  i_wb_cpu_adr, i_wb_cpu_dat, i_wb_cpu_sel, i_wb_cpu_we, i_wb_cpu_cyc,
        output o_wb_cpu_rdt, o_wb_cpu_ack,
        output o_wb_s_adr, o_wb_s_dat, o_wb_s_sel, o_wb_s_we, o_wb_s_cyc,
        input  i_wb_s_rdt, i_wb_s_ack,
        output o_err, o_err_adr,
        input  i_err_clr
    );

    modport master (
        output i_wb_cpu_adr, i_wb_cpu_dat, i_wb_cpu_sel, i_wb_cpu_we, i_wb_cpu_cyc,
        input  o_wb_cpu_rdt, o_wb_cpu_ack,
        input  o_wb_s_adr, o_wb_s_dat, o_wb_s_sel, o_wb_s_we, o_wb_s_cyc,
        output i_wb_s_rdt, i_wb_s_ack,
        input  o_err, o_err_adr,
        output i_err_clr
    );
endinterface

// File: rtl/servant_muxn.sv
// Address-decoding Wishbone interconnect: SERV data bus to NUM_SLAVES peripherals with bus-error logging.
// Define SERVANT_MUXN_TIMEOUT_EN to terminate stalled slave cycles after TIMEOUT busy cycles.
module servant_muxn #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_BITS   = 2,
    parameter int TIMEOUT    = 255
) (
    input logic         i_clk,
    input logic         i_rst,
    servant_muxn_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                state, state_n;
    logic [SEL_BITS-1:0]   idx, idx_n;
    logic [SEL_BITS-1:0]   cpu_idx;
    logic                  mapped;
    logic [31:0]           rdt, rdt_n;
    logic                  ack;
    logic                  err;
    logic                  err_set;
    logic [31:0]           err_adr;
    logic                  sel_ack;
    logic [31:0]           sel_rdt;
    logic [NUM_SLAVES-1:0] s_cyc;
    logic                  timeout;

    assign bus.o_wb_s_adr   = bus.i_wb_cpu_adr;
    assign bus.o_wb_s_dat   = bus.i_wb_cpu_dat;
    assign bus.o_wb_s_sel   = bus.i_wb_cpu_sel;
    assign bus.o_wb_s_we    = bus.i_wb_cpu_we;
    assign bus.o_wb_s_cyc   = s_cyc;
    assign bus.o_wb_cpu_rdt = rdt;
    assign bus.o_wb_cpu_ack = ack;
    assign bus.o_err        = err;
    assign bus.o_err_adr    = err_adr;

    assign cpu_idx = bus.i_wb_cpu_adr[31 -: SEL_BITS];
    assign mapped  = {1'b0, cpu_idx} < (SEL_BITS+1)'(NUM_SLAVES);

    // Slave cyc is gated by the live CPU cyc so an abort drops it in the same cycle.
    always_comb begin
        sel_ack = 1'b0;
        sel_rdt = '0;
        s_cyc   = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (idx == k[SEL_BITS-1:0]) begin
                sel_ack  = bus.i_wb_s_ack[k];
                sel_rdt  = bus.i_wb_s_rdt[32*k +: 32];
                s_cyc[k] = (state == BUSY) && bus.i_wb_cpu_cyc;
            end
        end
    end

`ifdef SERVANT_MUXN_TIMEOUT_EN
    logic [15:0] cnt;

    assign timeout = (cnt == 16'(TIMEOUT - 1));

    // BUSY is only entered from IDLE, so clearing while idle is a clear on entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (state == BUSY && !sel_ack) begin
            cnt <= cnt + 16'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        idx_n   = idx;
        rdt_n   = rdt;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_wb_cpu_cyc) begin
                    idx_n = cpu_idx;
                    if (mapped) begin
                        state_n = BUSY;
                    end else begin
                        state_n = ACK;
                        rdt_n   = '0;
                        err_set = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!bus.i_wb_cpu_cyc) begin
                    state_n = IDLE;
                end else if (sel_ack) begin
                    state_n = ACK;
                    rdt_n   = sel_rdt;
                end else if (timeout) begin
                    state_n = ACK;
                    rdt_n   = 32'hDEADBEEF;
                    err_set = 1'b1;
                end
            end
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            idx     <= '0;
            rdt     <= '0;
            ack     <= 1'b0;
            err     <= 1'b0;
            err_adr <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            rdt   <= rdt_n;
            ack   <= (state_n == ACK);
            if (bus.i_err_clr) begin
                err     <= 1'b0;
                err_adr <= '0;
            end else if (err_set) begin
                err <= 1'b1;
                if (!err) begin
                    err_adr <= bus.i_wb_cpu_adr;
                end
            end
        end
    end
endmodule

// File: tb/tb_servant_muxn.sv
// Bench for servant_muxn with three slaves (address field 3 unmapped): vector table,
// hand-written corner sequences and randomized traffic against a transaction-level model.
module tb_servant_muxn;
    localparam int NS = 3;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic        m_err;
    logic [31:0] m_err_adr;

    servant_muxn_if #(.NUM_SLAVES(NS)) bus ();

    servant_muxn #(.NUM_SLAVES(NS), .SEL_BITS(2), .TIMEOUT(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          waits;
        logic [31:0] word;
        int          exp_lat;
        logic [31:0] exp_rdt;
        logic        exp_err;
        logic [31:0] exp_err_adr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Target slave gets word, every other slave its complement.
    task automatic set_slaves(input logic [31:0] adr, input logic [31:0] word);
        for (int k = 0; k < NS; k++)
            bus.i_wb_s_rdt[32*k +: 32] = (k == int'(adr[31:30])) ? word : ~word;
    endtask

    task automatic clear_err();
        @(negedge clk);
        bus.i_err_clr = 1'b1;
        @(negedge clk);
        bus.i_err_clr = 1'b0;
        m_err     = 1'b0;
        m_err_adr = '0;
    endtask

    // Runs one CPU cycle; the addressed slave acks after `waits` wait states.
    task automatic run_txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, input int waits,
                           output int lat, output logic [31:0] rdt, output logic side_bad);
        int   seen;
        bit   done;
        int   sidx;
        logic [NS-1:0] oh;
        sidx = int'(adr[31:30]);
        oh   = (sidx < NS) ? NS'(1 << sidx) : '0;
        @(negedge clk);
        bus.i_wb_cpu_adr = adr;
        bus.i_wb_cpu_dat = dat;
        bus.i_wb_cpu_sel = sel;
        bus.i_wb_cpu_we  = we;
        bus.i_wb_cpu_cyc = 1'b1;
        #1;
        side_bad = (bus.o_wb_s_adr !== adr) || (bus.o_wb_s_dat !== dat) ||
                   (bus.o_wb_s_sel !== sel) || (bus.o_wb_s_we !== we);
        seen = 0;
        done = 0;
        lat  = -1;
        rdt  = 'x;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            bus.i_wb_s_ack = '0;
            if (bus.o_wb_cpu_ack) begin
                done = 1;
                lat  = c;
                rdt  = bus.o_wb_cpu_rdt;
            end else begin
                if (bus.o_wb_s_cyc !== '0 && bus.o_wb_s_cyc !== oh) side_bad = 1'b1;
                if (bus.o_wb_s_cyc === oh && sidx < NS) begin
                    if (seen == waits) bus.i_wb_s_ack[sidx] = 1'b1;
                    seen++;
                end
            end
        end
        bus.i_wb_cpu_cyc = 1'b0;
        bus.i_wb_s_ack   = '0;
    endtask

    vec_t        vecs[5];
    int          lat;
    logic [31:0] rdt;
    logic        side_bad;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h80000004, 32'h0,        4'hF, 1'b0, 0, 32'h12345678, 2, 32'h12345678, 1'b0, 32'h0};
        vecs[1] = '{32'h40000000, 32'hA5A5A5A5, 4'hF, 1'b1, 3, 32'h0BADF00D, 5, 32'h0BADF00D, 1'b0, 32'h0};
        vecs[2] = '{32'h00000100, 32'h0,        4'h3, 1'b0, 1, 32'hCAFEF00D, 3, 32'hCAFEF00D, 1'b0, 32'h0};
        vecs[3] = '{32'hC0000010, 32'h0,        4'hF, 1'b0, 0, 32'h11111111, 1, 32'h0,        1'b1, 32'hC0000010};
        vecs[4] = '{32'hC0000020, 32'h0,        4'hF, 1'b0, 0, 32'h22222222, 1, 32'h0,        1'b1, 32'hC0000010};

        rst = 1'b1;
        bus.i_wb_cpu_adr = 32'h80000004;
        bus.i_wb_cpu_dat = '0;
        bus.i_wb_cpu_sel = 4'hF;
        bus.i_wb_cpu_we  = 1'b0;
        bus.i_wb_cpu_cyc = 1'b1;
        bus.i_wb_s_rdt   = '0;
        bus.i_wb_s_ack   = '0;
        bus.i_err_clr    = 1'b0;
        m_err     = 1'b0;
        m_err_adr = '0;

        // Reset held with a live CPU cycle.
        repeat (2) @(negedge clk);
        check("rst_ack", 32'(bus.o_wb_cpu_ack), 32'h0);
        check("rst_scyc", 32'(bus.o_wb_s_cyc), 32'h0);
        check("rst_err", 32'(bus.o_err), 32'h0);
        check("rst_rdt", bus.o_wb_cpu_rdt, 32'h0);
        check("rst_err_adr", bus.o_err_adr, 32'h0);
        rst = 1'b0;
        bus.i_wb_cpu_cyc = 1'b0;

        for (int i = 0; i < 5; i++) begin
            set_slaves(vecs[i].adr, vecs[i].word);
            run_txn(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].we, vecs[i].waits, lat, rdt, side_bad);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_rdt", i), rdt, vecs[i].exp_rdt);
            check($sformatf("vec%0d_err", i), 32'(bus.o_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_err_adr", i), bus.o_err_adr, vecs[i].exp_err_adr);
            check($sformatf("vec%0d_side", i), 32'(side_bad), 32'h0);
        end
        m_err     = 1'b1;
        m_err_adr = 32'hC0000010;

        clear_err();
        check("clr_err", 32'(bus.o_err), 32'h0);
        check("clr_err_adr", bus.o_err_adr, 32'h0);

        // Clear in the same cycle as a new unmapped error keeps the flag clear.
        @(negedge clk);
        bus.i_wb_cpu_adr = 32'hC0000030;
        bus.i_wb_cpu_cyc = 1'b1;
        bus.i_err_clr    = 1'b1;
        @(negedge clk);
        bus.i_err_clr    = 1'b0;
        bus.i_wb_cpu_cyc = 1'b0;
        check("clrprio_ack", 32'(bus.o_wb_cpu_ack), 32'h1);
        check("clrprio_err", 32'(bus.o_err), 32'h0);
        check("clrprio_err_adr", bus.o_err_adr, 32'h0);
        @(negedge clk);
        check("clrprio_err_after", 32'(bus.o_err), 32'h0);

        // Abort in BUSY, with a stray ack from a non-selected slave.
        set_slaves(32'h40000000, 32'h55AA55AA);
        @(negedge clk);
        bus.i_wb_cpu_adr = 32'h40000000;
        bus.i_wb_cpu_we  = 1'b0;
        bus.i_wb_cpu_cyc = 1'b1;
        @(negedge clk);
        check("abort_scyc_busy", 32'(bus.o_wb_s_cyc), 32'h2);
        bus.i_wb_s_ack[2] = 1'b1;
        @(negedge clk);
        bus.i_wb_s_ack = '0;
        check("stray_ack_noack", 32'(bus.o_wb_cpu_ack), 32'h0);
        check("stray_ack_scyc", 32'(bus.o_wb_s_cyc), 32'h2);
        bus.i_wb_cpu_cyc = 1'b0;
        #1;
        check("abort_scyc_drop", 32'(bus.o_wb_s_cyc), 32'h0);
        @(negedge clk);
        check("abort_noack", 32'(bus.o_wb_cpu_ack), 32'h0);
        set_slaves(32'h00000000, 32'h01020304);
        run_txn(32'h00000000, 32'h0, 4'hF, 1'b0, 0, lat, rdt, side_bad);
        check("post_abort_lat", 32'(lat), 32'd2);
        check("post_abort_rdt", rdt, 32'h01020304);

        // Reset in the middle of a transaction.
        set_slaves(32'h80000000, 32'h77777777);
        @(negedge clk);
        bus.i_wb_cpu_adr = 32'h80000000;
        bus.i_wb_cpu_cyc = 1'b1;
        @(negedge clk);
        check("midrst_scyc_busy", 32'(bus.o_wb_s_cyc), 32'h4);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_scyc", 32'(bus.o_wb_s_cyc), 32'h0);
        check("midrst_ack", 32'(bus.o_wb_cpu_ack), 32'h0);
        rst = 1'b0;
        bus.i_wb_cpu_cyc = 1'b0;
        @(negedge clk);
        check("midrst_ack_after", 32'(bus.o_wb_cpu_ack), 32'h0);
        check("midrst_rdt", bus.o_wb_cpu_rdt, 32'h0);

`ifdef SERVANT_MUXN_TIMEOUT_EN
        set_slaves(32'h00000040, 32'h13572468);
        run_txn(32'h00000040, 32'h0, 4'hF, 1'b0, 1000, lat, rdt, side_bad);
        check("tmo_lat", 32'(lat), 32'd9);
        check("tmo_rdt", rdt, 32'hDEADBEEF);
        check("tmo_err", 32'(bus.o_err), 32'h1);
        check("tmo_err_adr", bus.o_err_adr, 32'h00000040);
        clear_err();
        run_txn(32'h00000040, 32'h0, 4'hF, 1'b0, 7, lat, rdt, side_bad);
        check("lastack_lat", 32'(lat), 32'd9);
        check("lastack_rdt", rdt, 32'h13572468);
        check("lastack_err", 32'(bus.o_err), 32'h0);
`else
        set_slaves(32'h00000040, 32'h13572468);
        run_txn(32'h00000040, 32'h0, 4'hF, 1'b0, 30, lat, rdt, side_bad);
        check("longwait_lat", 32'(lat), 32'd32);
        check("longwait_rdt", rdt, 32'h13572468);
        check("longwait_err", 32'(bus.o_err), 32'h0);
`endif

        // Randomized traffic against the transaction-level model.
        m_err     = bus.o_err === 1'b1 ? 1'b1 : 1'b0;
        clear_err();
        for (int n = 0; n < 150; n++) begin
            logic [31:0] adr, dat, words[NS], exp_rdt;
            logic [3:0]  sel;
            logic        we;
            int          waits, sidx, exp_lat;
            adr   = $urandom;
            dat   = $urandom;
            sel   = 4'($urandom_range(0, 15));
            we    = 1'($urandom_range(0, 1));
            waits = $urandom_range(0, 4);
            for (int k = 0; k < NS; k++) begin
                words[k] = $urandom;
                bus.i_wb_s_rdt[32*k +: 32] = words[k];
            end
            sidx = int'(adr[31:30]);
            if (sidx < NS) begin
                exp_lat = 2 + waits;
                exp_rdt = words[sidx];
            end else begin
                exp_lat = 1;
                exp_rdt = '0;
                if (!m_err) m_err_adr = adr;
                m_err = 1'b1;
            end
            run_txn(adr, dat, sel, we, waits, lat, rdt, side_bad);
            check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_rdt", n), rdt, exp_rdt);
            check($sformatf("rnd%0d_err", n), 32'(bus.o_err), 32'(m_err));
            check($sformatf("rnd%0d_err_adr", n), bus.o_err_adr, m_err_adr);
            check($sformatf("rnd%0d_side", n), 32'(side_bad), 32'h0);
            if ($urandom_range(0, 7) == 0) clear_err();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/servant_muxn.md
# servant_muxn

Parametrised Wishbone address-decoding interconnect between the SERV CPU data bus and `NUM_SLAVES` peripherals. Replaces the fixed two-way gpio/timer splitter. The block decodes the upper address bits, forwards the cycle to one slave and waits for that slave's own ack before acking the CPU. Unmapped addresses, and optionally slave timeouts, terminate with a bus error record instead of hanging the core.

## Interface
Parameters:
- `NUM_SLAVES`, default 4: number of slave ports, 1..2^`SEL_BITS`.
- `SEL_BITS`, default 2: decode field width, taken from `i_wb_cpu_adr[31 -: SEL_BITS]`.
- `TIMEOUT`, default 255: cycles in BUSY before forced termination, 1..65535. Used only with `SERVANT_MUXN_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous active-high reset.
- `i_wb_cpu_adr` in 32: CPU address.
- `i_wb_cpu_dat` in 32: CPU write data.
- `i_wb_cpu_sel` in 4: CPU byte enables.
- `i_wb_cpu_we` in 1: CPU write enable.
- `i_wb_cpu_cyc` in 1: CPU cycle/strobe.
- `o_wb_cpu_rdt` out 32: registered read data.
- `o_wb_cpu_ack` out 1: registered single-cycle ack.
- `o_wb_s_adr` out 32: address broadcast to all slaves.
- `o_wb_s_dat` out 32: write data broadcast to all slaves.
- `o_wb_s_sel` out 4: byte enables broadcast to all slaves.
- `o_wb_s_we` out 1: write enable broadcast to all slaves.
- `o_wb_s_cyc` out `NUM_SLAVES`: one-hot per-slave cycle.
- `i_wb_s_rdt` in 32*`NUM_SLAVES`: slave read data; slave k at bits [32k+31:32k].
- `i_wb_s_ack` in `NUM_SLAVES`: per-slave ack.
- `o_err` out 1: sticky bus-error flag.
- `o_err_adr` out 32: address of the first error since the last clear.
- `i_err_clr` in 1: clears `o_err` and `o_err_adr`.

## Operation
- Broadcast outputs (`o_wb_s_adr`, `o_wb_s_dat`, `o_wb_s_sel`, `o_wb_s_we`) are direct combinational copies of the CPU inputs.
- FSM states are IDLE, BUSY and ACK.
- **IDLE:** on `i_wb_cpu_cyc`:
  - Latch `idx = adr[31 -: SEL_BITS]`.
  - If `idx < NUM_SLAVES`, go to BUSY.
  - Otherwise go to ACK with `rdt = 0`. Set `o_err`; if `o_err` was clear, also load `o_err_adr` with the address.
- **BUSY:**
  - `o_wb_s_cyc[idx] = i_wb_cpu_cyc`; every other bit is 0. This is combinational gating, so a CPU abort drops the slave cycle in the same cycle.
  - On `i_wb_s_ack[idx]`: register `rdt` from slice `idx`, go to ACK.
  - If `i_wb_cpu_cyc` drops, go to IDLE with no ack.
- **ACK:** `o_wb_cpu_ack = 1` for exactly one cycle, then IDLE. A cycle still asserted on the ACK cycle is not re-sampled until IDLE.
- Acks from non-selected slaves, and any ack outside BUSY, are ignored.
- `o_wb_cpu_rdt` holds its value until the next load. Writes load `rdt` from the slave slice, which the CPU ignores.
- Error logging:
  - `o_err_adr` captures only the first error.
  - `i_err_clr` has priority over a same-cycle new error: the flag stays cleared.

## Timing
- Reset values: state IDLE; `o_wb_cpu_ack` 0, `o_wb_cpu_rdt` 0, `o_wb_s_cyc` 0, `o_err` 0, `o_err_adr` 0, timeout counter 0.
- `i_rst` mid-transaction returns to IDLE on the next edge and no ack is issued.
- Mapped access with a zero-wait slave (slave acks its first cyc cycle):
  - Cycle 0: cyc sampled in IDLE.
  - Cycle 1: BUSY, slave cyc high, slave ack.
  - Cycle 2: ACK.
  - Latency is 2 cycles from cyc to ack; each slave wait state adds 1.
- Unmapped access acks 1 cycle after cyc is sampled.
- Back-to-back: at most one transaction per 3 cycles.

## Configuration
- `SERVANT_MUXN_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without the selected ack.
  - When the count reaches `TIMEOUT - 1` with no ack, go to ACK with `rdt = 32'hDEADBEEF`, drop the slave cyc and log an error as for unmapped accesses.
  - An ack arriving in the final counted cycle wins over the timeout.
- Macro undefined: no counter; BUSY waits indefinitely for the slave ack.

## Test plan
- **Reset:** hold `i_rst` for 2 cycles with `i_wb_cpu_cyc=1` -> ack 0, all `o_wb_s_cyc` 0, `o_err` 0.
- **Read, slave 2, zero wait:** slave 2 returns `32'h12345678`, CPU reads `adr=32'h80000004` -> `o_wb_s_cyc=4'b0100` in cycle 1, ack in cycle 2 with rdt `32'h12345678`.
- **Write, slave 1, 3 wait states:** `adr=32'h40000000`, `dat=32'hA5A5A5A5`, `sel=4'hF` -> slave sees dat/sel/we, CPU ack at cycle 5, other slave cycs stay 0.
- **Unmapped** (`NUM_SLAVES=3`), access `32'hC0000010` -> ack 1 cycle later, rdt 0, `o_err=1`, `o_err_adr=32'hC0000010`. A second unmapped access to `32'hC0000020` leaves `o_err_adr` unchanged. `i_err_clr` -> both clear.
- **Timeout** (macro on, `TIMEOUT=8`), slave 0 never acks -> CPU ack 8 cycles after entering BUSY, rdt `32'hDEADBEEF`, `o_err=1`.
- **Abort:** CPU drops cyc in BUSY before the slave acks -> slave cyc drops the same cycle, no CPU ack, FSM back in IDLE next cycle.
